// File: rtl/bcd_line_decoder_seq.sv
// bcd_line_decoder_seq
// Buffers active-low BCD codes from a valid/ready stream in a small FIFO.
// Each code is replayed as a timed active-low one-of-nine line pulse followed by a gap.
// Code 0 produces a timed slot with every line high. Codes 10..15 are dropped and flagged on err.
// Optional feature macro: BCD_ERR_CNT_EN adds a saturating count of dropped codes on err_cnt.
// Without the macro, err_cnt is tied to zero.
module bcd_line_decoder_seq #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] Zn,
    output logic [8:0] An,
    output logic       busy,
    output logic       err,
    output logic [7:0] err_cnt
);

    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW   = $clog2(FIFO_DEPTH + 1);
    localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
    localparam logic [NW-1:0] FULL_COUNT = NW'(FIFO_DEPTH);
    localparam logic [8:0]    ALL_HIGH   = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        GAP
    } state_t;

    logic [3:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [NW-1:0] count;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] timer;
    logic [CW-1:0] timer_next;
    logic [8:0]    an_q;
    logic [8:0]    an_next;
    logic          err_q;
    logic          err_next;

    logic          push;
    logic          pop;
    logic [3:0]    head_code;

    // Active-low line pattern for a code; codes outside 1..9 leave every line high.
    function automatic logic [8:0] line_for(input logic [3:0] code);
        logic [8:0] r;
        r = ALL_HIGH;
        for (int i = 0; i < 9; i++) begin
            if (code == 4'(i + 1)) begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    // Readiness depends only on the registered count, so a pop cannot open room on the same edge.
    assign in_ready  = (count != FULL_COUNT);
    assign push      = in_valid && in_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign head_code = ~fifo_mem[rd_ptr];

    assign An   = an_q;
    assign err  = err_q;
    assign busy = (state != IDLE) || (count != '0);

    // Code storage; the contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= Zn;
        end
    end

    // FIFO pointers and occupancy; the pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
        end
    end

    // State, timer and registered outputs, so An and err never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
            an_q  <= ALL_HIGH;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            timer <= timer_next;
            an_q  <= an_next;
            err_q <= err_next;
        end
    end

    // Next-state logic: pop in IDLE, hold the line pattern in DRIVE, keep all lines high in GAP.
    always_comb begin
        state_next = state;
        timer_next = timer;
        an_next    = an_q;
        err_next   = 1'b0;
        unique case (state)
            IDLE: begin
                an_next = ALL_HIGH;
                if (pop) begin
                    if (head_code <= 4'd9) begin
                        state_next = DRIVE;
                        timer_next = PULSE_LOAD;
                        an_next    = line_for(head_code);
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            DRIVE: begin
                if (timer == '0) begin
                    an_next = ALL_HIGH;
                    if (GAP_CYCLES == 0) begin
                        state_next = IDLE;
                    end else begin
                        state_next = GAP;
                        timer_next = GAP_LOAD;
                    end
                end else begin
                    timer_next = timer - CW'(1);
                end
            end
            GAP: begin
                an_next = ALL_HIGH;
                if (timer == '0) begin
                    state_next = IDLE;
                end else begin
                    timer_next = timer - CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                an_next    = ALL_HIGH;
            end
        endcase
    end

`ifdef BCD_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Saturating tally of dropped codes, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= 8'h00;
        end else if (err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_bcd_line_decoder_seq.sv
// tb_bcd_line_decoder_seq
// Scoreboard bench: stimulus queues the code it expects to see replayed, and a monitor
// pops the queue whenever a line pulse starts or err fires.
// Build with BCD_ERR_CNT_EN defined to exercise the saturating error counter.
module tb_bcd_line_decoder_seq;

    localparam int PULSE = 4;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] Zn;
    logic [8:0] An;
    logic       busy;
    logic       err;
    logic [7:0] err_cnt;

    int         errors;
    int         checks;
    int         exp_q[$];
    bit         saw_full;

    bit         in_pulse;
    int         pulse_len;
    logic [8:0] pulse_val;
    int         mon_code;

    bcd_line_decoder_seq #(
        .PULSE_CYCLES(4),
        .GAP_CYCLES  (2),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .Zn      (Zn),
        .An      (An),
        .busy    (busy),
        .err     (err),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written active-low line patterns for codes 1..9.
    function automatic logic [8:0] expected_lines(input int code);
        case (code)
            1:       return 9'h1FE;
            2:       return 9'h1FD;
            3:       return 9'h1FB;
            4:       return 9'h1F7;
            5:       return 9'h1EF;
            6:       return 9'h1DF;
            7:       return 9'h1BF;
            8:       return 9'h17F;
            9:       return 9'h0FF;
            default: return 9'h1FF;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Offer one code and wait (bounded) for the handshake; visible responses go to the scoreboard.
    task automatic applyStimulus(input int code, input bit track);
        bit accepted;
        accepted = 1'b0;
        Zn       = ~code[3:0];
        in_valid = 1'b1;
        for (int t = 0; t < 100 && !accepted; t++) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
        end
        if (accepted && track && code != 0) begin
            exp_q.push_back(code);
        end
        if (!accepted) begin
            checkOutput("push_timeout", 32'd0, 32'd1);
        end
        #1;
        in_valid = 1'b0;
    endtask

    // Bounded wait for busy to fall; returns the number of edges it took.
    task automatic waitIdle(output int cycles);
        cycles = 0;
        while (busy && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (busy) begin
            checkOutput("idle_timeout", 32'd1, 32'd0);
        end
    endtask

    // Monitor: pops the scoreboard on each err pulse and each pulse start, and checks pulse length.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            in_pulse = 1'b0;
        end else begin
            if (in_ready === 1'b0) begin
                saw_full = 1'b1;
            end
            if (err === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checkOutput("err_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_code = exp_q.pop_front();
                    checkOutput("err_code_invalid", 32'(mon_code >= 10), 32'd1);
                    checkOutput("err_lines_high", 32'(An), 32'h1FF);
                end
            end
            if (An !== 9'h1FF) begin
                if (!in_pulse) begin
                    in_pulse  = 1'b1;
                    pulse_len = 1;
                    pulse_val = An;
                    if (exp_q.size() == 0) begin
                        checkOutput("pulse_unexpected", 32'(An), 32'h1FF);
                    end else begin
                        mon_code = exp_q.pop_front();
                        checkOutput("pulse_lines", 32'(An), 32'(expected_lines(mon_code)));
                    end
                end else begin
                    pulse_len++;
                    checkOutput("pulse_hold", 32'(An), 32'(pulse_val));
                end
            end else if (in_pulse) begin
                in_pulse = 1'b0;
                checkOutput("pulse_length", 32'(pulse_len), 32'(PULSE));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Directed stimulus sequence.
    initial begin
        int cyc;
        errors   = 0;
        checks   = 0;
        saw_full = 1'b0;
        in_pulse = 1'b0;
        rst      = 1'b1;
        in_valid = 1'b0;
        Zn       = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_An", 32'(An), 32'h1FF);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        checkOutput("reset_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] single code 5");
        applyStimulus(5, 1'b1);
        checkOutput("latency_before", 32'(An), 32'h1FF);
        @(posedge clk);
        #1;
        checkOutput("latency_drive", 32'(An), 32'h1EF);
        waitIdle(cyc);
        checkOutput("single_busy_span", 32'(cyc), 32'd6);

        $display("[TB] back-to-back 9,1,3,7,2,8");
        saw_full = 1'b0;
        applyStimulus(9, 1'b1);
        applyStimulus(1, 1'b1);
        applyStimulus(3, 1'b1);
        applyStimulus(7, 1'b1);
        applyStimulus(2, 1'b1);
        applyStimulus(8, 1'b1);
        waitIdle(cyc);
        checkOutput("b2b_ready_dropped", 32'(saw_full), 32'd1);
        checkOutput("b2b_all_replayed", 32'(exp_q.size()), 32'd0);

        $display("[TB] invalid code 12 then 4");
        applyStimulus(12, 1'b1);
        applyStimulus(4, 1'b1);
        checkOutput("err_pulse", 32'(err), 32'd1);
        checkOutput("err_An", 32'(An), 32'h1FF);
        @(posedge clk);
        #1;
        checkOutput("err_one_cycle", 32'(err), 32'd0);
        checkOutput("after_err_An", 32'(An), 32'h1F7);
        waitIdle(cyc);
`ifdef BCD_ERR_CNT_EN
        checkOutput("err_cnt_one", 32'(err_cnt), 32'd1);
`else
        checkOutput("err_cnt_tied", 32'(err_cnt), 32'd0);
`endif

        $display("[TB] code 0 slot");
        applyStimulus(0, 1'b1);
        checkOutput("zero_busy_start", 32'(busy), 32'd1);
        waitIdle(cyc);
        checkOutput("zero_busy_span", 32'(cyc), 32'd7);

        $display("[TB] reset during DRIVE");
        applyStimulus(6, 1'b1);
        applyStimulus(3, 1'b1);
        applyStimulus(2, 1'b1);
        checkOutput("pre_reset_drive", 32'(An), 32'h1DF);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_An", 32'(An), 32'h1FF);
        checkOutput("async_reset_busy", 32'(busy), 32'd0);
        checkOutput("async_reset_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("fifo_flushed_busy", 32'(busy), 32'd0);
        checkOutput("fifo_flushed_An", 32'(An), 32'h1FF);
        checkOutput("reset_clears_err_cnt", 32'(err_cnt), 32'd0);

`ifdef BCD_ERR_CNT_EN
        $display("[TB] 300 invalid codes");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(10 + (i % 6), 1'b1);
        end
        waitIdle(cyc);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("err_cnt_saturated", 32'(err_cnt), 32'hFF);
`endif

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
